// File: rtl/johnson_decoder.sv
// Johnson code receiver: legality check, index decode,
// successor tracking with lock acquisition and error counting.
module johnson_decoder #(
  parameter  int N        = 4,
  parameter  int LOCK_LEN = 4,
  parameter  int ERR_W    = 8,
  localparam int IW       = $clog2(2 * N),
  localparam int SW       = $clog2(LOCK_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     code_in,
  input  logic             code_valid,
  output logic [IW-1:0]    index,
  output logic             index_valid,
  output logic             illegal,
  output logic             step_err,
  output logic             wrap,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_HUNT,
    S_ACQ,
    S_LOCK
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(2 * N - 1);

  state_t          r_state;
  logic [SW-1:0]   r_step;
  logic [IW-1:0]   r_index;
  logic            r_iv;
  logic            r_ill;
  logic            r_se;
  logic            r_wrap;
  logic            r_locked;
  logic [ERR_W-1:0] r_err;

  logic [N-1:0]    w_inv;
  logic [N-1:0]    w_lo_p1;
  logic [N-1:0]    w_hi_p1;
  logic            w_legal;
  logic [IW-1:0]   w_pop;
  logic [IW-1:0]   w_dec;
  logic [IW-1:0]   w_expect;
  logic            w_succ;

  state_t          w_nstate;
  logic [SW-1:0]   w_nstep;
  logic [IW-1:0]   w_nindex;
  logic            w_iv;
  logic            w_ill;
  logic            w_se;
  logic            w_wrap;

  // A legal code is a ones-run anchored at bit 0, or a
  // zeros-run anchored at bit 0 (ones anchored at the MSB).
  always_comb begin
    w_inv   = ~code_in;
    w_lo_p1 = code_in + N'(1);
    w_hi_p1 = w_inv + N'(1);
    w_legal = ((code_in & w_lo_p1) == '0)
           || ((w_inv & w_hi_p1) == '0);
    w_pop = '0;
    for (int i = 0; i < N; i++) begin
      w_pop = w_pop + IW'(code_in[i]);
    end
    if (code_in[0] || (code_in == '0)) begin
      w_dec = w_pop;
    end else begin
      w_dec = IW'(2 * N) - w_pop;
    end
    w_expect = (r_index == LAST) ? '0 : r_index + IW'(1);
    w_succ   = (w_dec == w_expect);
  end

  // Next-state and pulse selection for each valid sample.
  always_comb begin
    w_nstate = r_state;
    w_nstep  = r_step;
    w_nindex = r_index;
    w_iv     = 1'b0;
    w_ill    = 1'b0;
    w_se     = 1'b0;
    w_wrap   = 1'b0;
    if (code_valid) begin
      if (!w_legal) begin
        w_ill    = 1'b1;
        w_nstate = S_HUNT;
        w_nstep  = '0;
      end else begin
        w_iv     = 1'b1;
        w_nindex = w_dec;
        unique case (r_state)
          S_HUNT: begin
            w_nstate = S_ACQ;
            w_nstep  = '0;
          end
          S_ACQ: begin
            if (w_succ) begin
              w_wrap  = (r_index == LAST);
              w_nstep = r_step + SW'(1);
              if (r_step == SW'(LOCK_LEN - 1)) begin
                w_nstate = S_LOCK;
              end
            end else begin
              w_nstep = '0;
            end
          end
          S_LOCK: begin
            if (w_succ) begin
              w_wrap = (r_index == LAST);
            end else begin
              w_se     = 1'b1;
              w_nstate = S_ACQ;
              w_nstep  = '0;
            end
          end
          default: begin
            w_nstate = S_HUNT;
            w_nstep  = '0;
          end
        endcase
      end
    end
  end

  // State, registered outputs and saturating error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_HUNT;
      r_step   <= '0;
      r_index  <= '0;
      r_iv     <= 1'b0;
      r_ill    <= 1'b0;
      r_se     <= 1'b0;
      r_wrap   <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= '0;
    end else begin
      r_state  <= w_nstate;
      r_step   <= w_nstep;
      r_index  <= w_nindex;
      r_iv     <= w_iv;
      r_ill    <= w_ill;
      r_se     <= w_se;
      r_wrap   <= w_wrap;
      r_locked <= (w_nstate == S_LOCK);
      if ((w_ill || w_se) && (r_err != '1)) begin
        r_err <= r_err + ERR_W'(1);
      end
    end
  end

  assign index       = r_index;
  assign index_valid = r_iv;
  assign illegal     = r_ill;
  assign step_err    = r_se;
  assign wrap        = r_wrap;
  assign locked      = r_locked;
  assign err_count   = r_err;

endmodule

// File: tb/tb_johnson_decoder.sv
// Bench for johnson_decoder: directed vector table plus
// randomized traffic against a lookup-table reference model.
module tb_johnson_decoder;

  localparam int N  = 4;
  localparam int LL = 4;
  localparam int NS = 2 * N;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] code_in;
  logic       code_valid;

  logic [2:0] index, index2;
  logic       iv, iv2, ill, ill2, se, se2;
  logic       wr, wr2, lk, lk2;
  logic [7:0] err;
  logic [1:0] err2;

  johnson_decoder #(.N(N), .LOCK_LEN(LL), .ERR_W(8)) u_dut (
    .clk(clk), .reset(reset),
    .code_in(code_in), .code_valid(code_valid),
    .index(index), .index_valid(iv),
    .illegal(ill), .step_err(se), .wrap(wr),
    .locked(lk), .err_count(err)
  );

  johnson_decoder #(.N(N), .LOCK_LEN(LL), .ERR_W(2)) u_sat (
    .clk(clk), .reset(reset),
    .code_in(code_in), .code_valid(code_valid),
    .index(index2), .index_valid(iv2),
    .illegal(ill2), .step_err(se2), .wrap(wr2),
    .locked(lk2), .err_count(err2)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  // Reference model: code table built from the k-rule.
  int jc[NS];
  int m_idx, m_streak, m_err, m_err2;
  bit m_has, m_lk;
  int e_iv, e_ill, e_se, e_wr;

  task automatic model_update(input bit rst, input bit v,
                              input int code);
    int k;
    e_iv = 0; e_ill = 0; e_se = 0; e_wr = 0;
    if (rst) begin
      m_has = 0; m_idx = 0; m_streak = 0; m_lk = 0;
      m_err = 0; m_err2 = 0;
      return;
    end
    if (!v) return;
    k = -1;
    for (int i = 0; i < NS; i++)
      if (jc[i] == code) k = i;
    if (k < 0) begin
      e_ill = 1; m_has = 0; m_lk = 0; m_streak = 0;
    end else begin
      e_iv = 1;
      if (!m_has) begin
        m_has = 1; m_streak = 0;
      end else if (k == (m_idx + 1) % NS) begin
        e_wr = (m_idx == NS - 1) ? 1 : 0;
        if (m_streak < LL) m_streak++;
        m_lk = (m_streak >= LL);
      end else begin
        e_se = m_lk ? 1 : 0;
        m_streak = 0; m_lk = 0;
      end
      m_idx = k;
    end
    if (e_ill != 0 || e_se != 0) begin
      if (m_err < 255) m_err++;
      if (m_err2 < 3) m_err2++;
    end
  endtask

  task automatic apply(input bit rst, input bit v,
                       input int code);
    reset      = rst;
    code_valid = v;
    code_in    = 4'(code);
    @(posedge clk);
    #1;
    model_update(rst, v, code);
  endtask

  task automatic chk_model();
    chk("index", int'(index), m_idx);
    chk("index_valid", int'(iv), e_iv);
    chk("illegal", int'(ill), e_ill);
    chk("step_err", int'(se), e_se);
    chk("wrap", int'(wr), e_wr);
    chk("locked", int'(lk), int'(m_lk));
    chk("err_count", int'(err), m_err);
    chk("index_w2", int'(index2), m_idx);
    chk("pulses_w2", int'({iv2, ill2, se2, wr2}),
        (e_iv << 3) | (e_ill << 2) | (e_se << 1) | e_wr);
    chk("locked_w2", int'(lk2), int'(m_lk));
    chk("err_sat", int'(err2), m_err2);
  endtask

  typedef struct {
    bit rst; bit v; int code;
    int idx; int iv; int ill; int se; int wr; int lk;
    int err; int err2;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit v, input int c,
                     input int ix, input int a, input int b,
                     input int s, input int w, input int l,
                     input int e, input int e2);
    vec_t t;
    t.rst = r; t.v = v; t.code = c;
    t.idx = ix; t.iv = a; t.ill = b; t.se = s;
    t.wr = w; t.lk = l; t.err = e; t.err2 = e2;
    tbl.push_back(t);
  endtask

  initial begin
    int r, c;
    for (int k = 0; k < NS; k++) begin
      if (k <= N) jc[k] = (1 << k) - 1;
      else jc[k] = ((1 << N) - 1) ^ ((1 << (k - N)) - 1);
    end
    reset = 1'b1; code_valid = 1'b0; code_in = '0;

    add(1,0,0,  0,0,0,0,0,0, 0,0);
    add(0,1,0,  0,1,0,0,0,0, 0,0);
    add(0,1,1,  1,1,0,0,0,0, 0,0);
    add(0,1,3,  2,1,0,0,0,0, 0,0);
    add(0,1,7,  3,1,0,0,0,0, 0,0);
    add(0,1,15, 4,1,0,0,0,1, 0,0);
    add(0,1,14, 5,1,0,0,0,1, 0,0);
    add(0,1,12, 6,1,0,0,0,1, 0,0);
    add(0,1,8,  7,1,0,0,0,1, 0,0);
    add(0,1,0,  0,1,0,0,1,1, 0,0);
    add(0,1,5,  0,0,1,0,0,0, 1,1);
    add(0,1,3,  2,1,0,0,0,0, 1,1);
    add(0,1,7,  3,1,0,0,0,0, 1,1);
    add(0,1,15, 4,1,0,0,0,0, 1,1);
    add(0,1,14, 5,1,0,0,0,0, 1,1);
    add(0,1,12, 6,1,0,0,0,1, 1,1);
    add(0,1,8,  7,1,0,0,0,1, 1,1);
    add(0,1,0,  0,1,0,0,1,1, 1,1);
    add(0,1,1,  1,1,0,0,0,1, 1,1);
    add(0,1,3,  2,1,0,0,0,1, 1,1);
    add(0,1,7,  3,1,0,0,0,1, 1,1);
    add(0,1,7,  3,1,0,1,0,0, 2,2);
    add(0,1,15, 4,1,0,0,0,0, 2,2);
    add(0,1,14, 5,1,0,0,0,0, 2,2);
    add(0,1,12, 6,1,0,0,0,0, 2,2);
    add(0,1,8,  7,1,0,0,0,1, 2,2);
    add(0,1,0,  0,1,0,0,1,1, 2,2);
    add(0,0,5,  0,0,0,0,0,1, 2,2);
    add(0,0,5,  0,0,0,0,0,1, 2,2);
    add(0,0,5,  0,0,0,0,0,1, 2,2);
    add(0,1,1,  1,1,0,0,0,1, 2,2);
    add(1,1,3,  0,0,0,0,0,0, 0,0);
    add(0,1,1,  1,1,0,0,0,0, 0,0);
    add(0,1,15, 4,1,0,0,0,0, 0,0);
    add(0,1,14, 5,1,0,0,0,0, 0,0);
    add(0,1,5,  5,0,1,0,0,0, 1,1);
    add(0,1,10, 5,0,1,0,0,0, 2,2);
    add(0,1,9,  5,0,1,0,0,0, 3,3);
    add(0,1,6,  5,0,1,0,0,0, 4,3);
    add(0,1,11, 5,0,1,0,0,0, 5,3);
    add(0,0,15, 5,0,0,0,0,0, 5,3);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].v, tbl[i].code);
      chk($sformatf("v%0d.index", i), int'(index), tbl[i].idx);
      chk($sformatf("v%0d.valid", i), int'(iv), tbl[i].iv);
      chk($sformatf("v%0d.illegal", i), int'(ill), tbl[i].ill);
      chk($sformatf("v%0d.step_err", i), int'(se), tbl[i].se);
      chk($sformatf("v%0d.wrap", i), int'(wr), tbl[i].wr);
      chk($sformatf("v%0d.locked", i), int'(lk), tbl[i].lk);
      chk($sformatf("v%0d.err", i), int'(err), tbl[i].err);
      chk($sformatf("v%0d.err_sat", i), int'(err2), tbl[i].err2);
    end

    apply(1, 0, 0);
    chk_model();
    for (int n = 0; n < 800; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        apply(1, 1, jc[$urandom_range(0, NS - 1)]);
      end else if (r < 60) begin
        apply(0, 1, jc[(m_idx + 1) % NS]);
      end else if (r < 75) begin
        apply(0, 1, jc[$urandom_range(0, NS - 1)]);
      end else if (r < 87) begin
        c = int'($urandom_range(0, 15));
        apply(0, 1, c);
      end else begin
        c = int'($urandom_range(0, 15));
        apply(0, 0, c);
      end
      chk_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
